// File: rtl/step3_action_select.sv
// PBVI backup stage 3: per belief point, picks the action whose alpha vector scores highest.
// Optional macro STEP3_CONVERGENCE_CHECK_EN adds a run-to-run alpha convergence flag.
module step3_action_select #(
  parameter int unsigned NUM_ACTIONS = 3,
  parameter int unsigned NUM_POINTS  = 16,
  parameter int unsigned NUM_STATES  = 2,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ACT_W       = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              en,
  input  logic [NUM_ACTIONS*NUM_POINTS*NUM_STATES*DATA_W-1:0] gamma_action_belief,
  input  logic [NUM_POINTS*NUM_STATES*DATA_W-1:0]           point_belief,
  output logic                                              busy,
  output logic                                              en_step4,
  output logic [NUM_POINTS*NUM_STATES*DATA_W-1:0]           alpha_new,
  output logic [NUM_POINTS*ACT_W-1:0]                       best_action,
  output logic                                              converged
);

  localparam int unsigned PtW   = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam int unsigned Guard = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 0;
  localparam int unsigned ProdW = 2 * DATA_W + 1;
  localparam int unsigned SumW  = ProdW + Guard;
  localparam int unsigned RowW  = NUM_STATES * DATA_W;
  localparam int unsigned PbW   = NUM_POINTS * RowW;
  localparam int unsigned GamW  = NUM_ACTIONS * PbW;

  localparam logic [PtW-1:0]   PLast = PtW'(NUM_POINTS - 1);
  localparam logic [ACT_W-1:0] ALast = ACT_W'(NUM_ACTIONS - 1);

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  state_e                   state_q;
  logic [GamW-1:0]          gamma_q;
  logic [PbW-1:0]           belief_q;
  logic [PtW-1:0]           p_q;
  logic [ACT_W-1:0]         a_q;
  logic signed [SumW-1:0]   best_val_q;
  logic [ACT_W-1:0]         best_act_q;
  logic [PbW-1:0]           shadow_alpha_q;
  logic [NUM_POINTS*ACT_W-1:0] shadow_act_q;

  int unsigned              a_idx, p_idx;
  logic signed [DATA_W-1:0] alpha_el;
  logic signed [DATA_W:0]   belief_el;
  logic signed [ProdW-1:0]  prod;
  logic signed [SumW-1:0]   cur_val;
  logic                     take_cur;
  logic [ACT_W-1:0]         win_act;
  logic [RowW-1:0]          win_alpha;

  assign a_idx = 32'(a_q);
  assign p_idx = 32'(p_q);

  // Dot product of the current (point, action) alpha with the point's belief.
  always_comb begin
    cur_val   = '0;
    alpha_el  = '0;
    belief_el = '0;
    prod      = '0;
    for (int unsigned s = 0; s < NUM_STATES; s++) begin
      alpha_el  = gamma_q[((a_idx * NUM_POINTS + p_idx) * NUM_STATES + s) * DATA_W +: DATA_W];
      belief_el = {1'b0, belief_q[(p_idx * NUM_STATES + s) * DATA_W +: DATA_W]};
      prod      = ProdW'(alpha_el) * ProdW'(belief_el);
      cur_val   = cur_val + SumW'(prod);
    end
    // Action 0 seeds; later actions win only when strictly greater.
    take_cur  = (a_q == '0) || (cur_val > best_val_q);
    win_act   = take_cur ? a_q : best_act_q;
    win_alpha = gamma_q[(32'(win_act) * NUM_POINTS + p_idx) * RowW +: RowW];
  end

`ifdef STEP3_CONVERGENCE_CHECK_EN
  logic has_prev_q;
`else
  assign converged = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      gamma_q        <= '0;
      belief_q       <= '0;
      p_q            <= '0;
      a_q            <= '0;
      best_val_q     <= '0;
      best_act_q     <= '0;
      shadow_alpha_q <= '0;
      shadow_act_q   <= '0;
      alpha_new      <= '0;
      best_action    <= '0;
      busy           <= 1'b0;
      en_step4       <= 1'b0;
`ifdef STEP3_CONVERGENCE_CHECK_EN
      converged      <= 1'b0;
      has_prev_q     <= 1'b0;
`endif
    end else begin
      en_step4 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en) begin
            gamma_q  <= gamma_action_belief;
            belief_q <= point_belief;
            p_q      <= '0;
            a_q      <= '0;
            busy     <= 1'b1;
            state_q  <= StEval;
          end
        end
        StEval: begin
          if (take_cur) begin
            best_val_q <= cur_val;
            best_act_q <= a_q;
          end
          if (a_q == ALast) begin
            shadow_alpha_q[p_idx * RowW +: RowW]   <= win_alpha;
            shadow_act_q[p_idx * ACT_W +: ACT_W]   <= win_act;
            a_q <= '0;
            if (p_q == PLast) begin
              state_q <= StDone;
            end else begin
              p_q <= p_q + 1'b1;
            end
          end else begin
            a_q <= a_q + 1'b1;
          end
        end
        StDone: begin
          alpha_new   <= shadow_alpha_q;
          best_action <= shadow_act_q;
          en_step4    <= 1'b1;
          busy        <= 1'b0;
          state_q     <= StIdle;
`ifdef STEP3_CONVERGENCE_CHECK_EN
          converged   <= has_prev_q && (shadow_alpha_q == alpha_new);
          has_prev_q  <= 1'b1;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_step3_action_select.sv
// Randomized scoreboard bench for step3_action_select; expected results come from an
// arithmetic argmax model and are checked by a monitor on each en_step4 pulse.
module tb_step3_action_select;
  localparam int NA  = 3;
  localparam int NP  = 16;
  localparam int NS  = 2;
  localparam int DW  = 16;
  localparam int AW  = 2;
  localparam int PBW = NP * NS * DW;
  localparam int GW  = NA * PBW;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [GW-1:0]   gamma_action_belief;
  logic [PBW-1:0]  point_belief;
  logic            busy, en_step4, converged;
  logic [PBW-1:0]  alpha_new;
  logic [NP*AW-1:0] best_action;

  step3_action_select dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .gamma_action_belief (gamma_action_belief),
    .point_belief        (point_belief),
    .busy                (busy),
    .en_step4            (en_step4),
    .alpha_new           (alpha_new),
    .best_action         (best_action),
    .converged           (converged)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PBW-1:0]   alpha;
    logic [NP*AW-1:0] act;
    logic             conv;
    int               cyc;
  } exp_t;

  exp_t           exp_q[$];
  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  int             pulses = 0;
  logic           en4_prev = 1'b0;
  logic [DW-1:0]  g_m[NA][NP][NS];
  logic [DW-1:0]  b_m[NP][NS];
  logic [PBW-1:0] prev_alpha = '0;
  int             runs_since_rst = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic chk_vec(input string name, input logic [PBW-1:0] got, input logic [PBW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: every en_step4 must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (en_step4) begin
      pulses++;
      chk_int("en_step4_width", int'(en4_prev), 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_en_step4: got=pulse at cycle %0d want=no pulse", cyc);
      end else begin
        e = exp_q.pop_front();
        chk_int("latency", cyc, e.cyc);
        chk_int("best_action", int'(best_action), int'(e.act));
        chk_vec("alpha_new", alpha_new, e.alpha);
        chk_int("converged", int'(converged), int'(e.conv));
      end
    end
    en4_prev = en_step4;
  end

  // Reference: plain integer dot products and a strict-greater argmax.
  task automatic model(output exp_t e);
    for (int p = 0; p < NP; p++) begin
      longint bv = 0;
      int     ba = 0;
      for (int a = 0; a < NA; a++) begin
        longint v = 0;
        for (int s = 0; s < NS; s++)
          v += longint'($signed(g_m[a][p][s])) * longint'(b_m[p][s]);
        if (a == 0 || v > bv) begin
          bv = v;
          ba = a;
        end
      end
      e.act[p*AW +: AW] = AW'(ba);
      for (int s = 0; s < NS; s++) e.alpha[(p*NS+s)*DW +: DW] = g_m[ba][p][s];
    end
`ifdef STEP3_CONVERGENCE_CHECK_EN
    e.conv = (runs_since_rst > 0) && (e.alpha == prev_alpha);
`else
    e.conv = 1'b0;
`endif
    prev_alpha = e.alpha;
    runs_since_rst++;
    e.cyc = 0;
  endtask

  task automatic drive();
    for (int a = 0; a < NA; a++)
      for (int p = 0; p < NP; p++)
        for (int s = 0; s < NS; s++)
          gamma_action_belief[((a*NP+p)*NS+s)*DW +: DW] = g_m[a][p][s];
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < NS; s++)
        point_belief[(p*NS+s)*DW +: DW] = b_m[p][s];
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < GW / 32; i++) gamma_action_belief[i*32 +: 32] = $urandom();
    for (int i = 0; i < PBW / 32; i++) point_belief[i*32 +: 32] = $urandom();
  endtask

  task automatic fill_nominal();
    for (int p = 0; p < NP; p++) begin
      g_m[0][p][0] = 16'd7209; g_m[0][p][1] = 16'd0;
      g_m[1][p][0] = 16'd0;    g_m[1][p][1] = 16'd7209;
      g_m[2][p][0] = 16'd6488; g_m[2][p][1] = 16'd6488;
      b_m[p][0] = 16'(p * 32'h1000);
      b_m[p][1] = 16'(32'hffff - p * 32'h1000);
    end
  endtask

  task automatic fill_random(input int mode);
    for (int a = 0; a < NA; a++)
      for (int p = 0; p < NP; p++)
        for (int s = 0; s < NS; s++) begin
          if (mode == 0) g_m[a][p][s] = 16'($urandom());
          else begin
            case ($urandom_range(0, 3))
              0: g_m[a][p][s] = 16'd0;
              1: g_m[a][p][s] = 16'd1;
              2: g_m[a][p][s] = 16'hffff;
              default: g_m[a][p][s] = 16'd100;
            endcase
          end
        end
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < NS; s++) b_m[p][s] = 16'($urandom());
  endtask

  task automatic do_run(input bit repulse);
    exp_t e;
    int   n;
    @(negedge clk);
    drive();
    model(e);
    e.cyc = cyc + 50;  // en edge is the next posedge; pulse follows 49 edges later
    exp_q.push_back(e);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    scramble_inputs();
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 5) chk_int("busy_eval", int'(busy), 1);
      if (repulse && n == 10) en = 1'b1;
      if (repulse && n == 11) en = 1'b0;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got=no en_step4 want=en_step4 within 100 cycles");
      exp_q.delete();
    end
    @(negedge clk);
    chk_int("busy_idle", int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_int({tag, "_busy"}, int'(busy), 0);
    chk_int({tag, "_en_step4"}, int'(en_step4), 0);
    chk_vec({tag, "_alpha_new"}, alpha_new, '0);
    chk_int({tag, "_best_action"}, int'(best_action), 0);
    chk_int({tag, "_converged"}, int'(converged), 0);
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    en = 1'b0;
    gamma_action_belief = '0;
    point_belief = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    fill_nominal();
    do_run(1'b0);
    chk_int("nom_act0", int'(best_action[0*AW +: AW]), 1);
    chk_int("nom_act8", int'(best_action[8*AW +: AW]), 2);
    chk_int("nom_act15", int'(best_action[15*AW +: AW]), 0);
    chk_int("nom_alpha15", int'(alpha_new[15*NS*DW +: 32]), 7209);

    for (int a = 0; a < NA; a++)
      for (int p = 0; p < NP; p++)
        for (int s = 0; s < NS; s++) g_m[a][p][s] = 16'd100;
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < NS; s++) b_m[p][s] = 16'($urandom());
    do_run(1'b0);
    chk_int("tie_act", int'(best_action), 0);
    chk_vec("tie_alpha", alpha_new, {(NP*NS){16'd100}});

    for (int p = 0; p < NP; p++) begin
      g_m[0][p][0] = 16'hffff; g_m[0][p][1] = 16'd0;
      g_m[1][p][0] = 16'h0001; g_m[1][p][1] = 16'd0;
      g_m[2][p][0] = 16'd0;    g_m[2][p][1] = 16'd0;
      b_m[p][0] = 16'h8000;    b_m[p][1] = 16'h7fff;
    end
    do_run(1'b0);
    chk_int("signed_act", int'(best_action), 32'h5555_5555);

    fill_random(0);
    do_run(1'b1);

    // Abandon a run part-way through EVAL.
    fill_random(0);
    @(negedge clk);
    drive();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runs_since_rst = 0;
    check_reset_outputs("midrun_reset");
    p0 = pulses;
    repeat (70) @(negedge clk);
    chk_int("no_pulse_after_reset", pulses, p0);

    fill_nominal();
    do_run(1'b0);
    do_run(1'b0);
    g_m[0][15][1] = 16'd5;
    do_run(1'b0);

    for (int i = 0; i < 8; i++) begin
      fill_random(i % 2);
      do_run(i == 3);
      if (i == 5) do_run(1'b0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
